uc_stack: RTL and testbench
===========================

Name: uc_stack

Overview:
- Parametrised successor to the single-cycle control unit `uc`.
- Decodes the 6-bit opcode and the registered zero flag into the datapath controls: s_inc, s_inm, we, wez, AluOP.
- Adds conditional branches, call/return through an internal return-address stack, and a sticky fault/halt state machine.
- Sits between instruction memory and the microc datapath; drives the PC mux and PC hold.

Parameters:
- OPC_W, 6, opcode width (must be 6 for this encoding; other values reserved).
- PC_W, 10, program-counter and return-address width.
- DEPTH, 4, return-stack entries (power of two, 2..64).
- SP_W, $clog2(DEPTH)+1, stack-pointer width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPC_W  current instruction opcode.
- zero  in  1  zero flag from the datapath flag register.
- pc_next  in  PC_W  PC+1 from the datapath; pushed on call.
- s_inc  out  1  1 = PC+1, 0 = jump target or return address.
- s_pila  out  1  1 = PC mux takes ret_addr (RET only).
- s_inm  out  1  1 = register-file write data from immediate.
- we  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- AluOP  out  3  ALU operation.
- ret_addr  out  PC_W  top-of-stack entry, i.e. stack[sp-1]; 0 when empty.
- sp  out  SP_W  number of valid entries, 0..DEPTH.
- halt  out  1  freeze the PC; asserted while in FAULT.

Behaviour:
- Outputs are combinational from opcode, zero and registered state. Stack and FSM update on the rising clk edge.
- Decode while in RUN (defaults: s_inc=1, all other outputs 0):
  - 0xxxxx ALU: AluOP=opcode[4:2], we=1, wez=1.
  - 10xxxx LI: s_inm=1, we=1.
  - 110000 J: s_inc=0.
  - 110001 JZ: s_inc=~zero.
  - 110010 JNZ: s_inc=zero.
  - 110011 JAL: s_inc=0; push pc_next at the edge, sp+1.
  - 110100 RET: s_inc=0, s_pila=1; pop at the edge, sp-1.
  - all other 11xxxx codes: NOP (defaults).
- FSM states:
  - RUN: normal decode.
  - FAULT: we=wez=0, s_inc=1, s_pila=0, AluOP=0, halt=1. FAULT holds until reset.
- RUN->FAULT on JAL with sp==DEPTH (overflow) or RET with sp==0 (underflow).
  - The faulting instruction already drives halt=1 and we=wez=0 in that same cycle.
  - The faulting instruction does not change the stack or sp.
- Push and pop never coincide (single opcode per cycle).
- Reset:
  - While reset=1: outputs forced to the FAULT values, except halt=0.
  - At the edge: sp=0, all stack entries 0, state RUN.
  - Reset mid-call sequence discards the whole stack.
- Latency:
  - Control signals are valid in the same cycle as the opcode.
  - Stack effects are visible from the next cycle.
- Back-to-back JAL/RET is legal. ret_addr after a RET equals the previous entry.

Optional Feature:
- UC_STACK_WRAP_EN defined: circular stack with no FAULT transitions.
  - Push when full overwrites the oldest entry; sp saturates at DEPTH.
  - Pop when empty returns stack[DEPTH-1] (stale) with sp=0; RET decodes normally.
  - halt is tied to 0.
- Undefined: fault behaviour as specified above.

Decomposition:
- Package uc_pkg holds:
  - opcode constants OP_J, OP_JZ, OP_JNZ, OP_JAL, OP_RET and prefixes ALU_PFX, LI_PFX;
  - state typedef {RUN, FAULT};
  - ALU op codes 3'b000..3'b111.
- One sub-module, uc_retstack: the LIFO storage with push, pop, sp, top, full and empty.
- Decode and FSM stay in uc_stack.

Test Plan (PC_W=8, DEPTH=4):
- Reset held 2 cycles, then opcode=100000 -> s_inm=1, we=1, wez=0, s_inc=1, sp=0, halt=0.
- ALU 001000 -> AluOP=010, we=1, wez=1. JZ with zero=1 -> s_inc=0. JZ with zero=0 -> s_inc=1. JNZ -> the opposite in each case.
- JAL with pc_next=0x11, 0x22, 0x33 -> sp=3, ret_addr=0x33. Then RET x3 -> s_pila=1 each cycle, ret_addr 0x33, 0x22, 0x11, final sp=0.
- Five JALs (0x01..0x05) -> the fifth sets halt=1 and we=0 in the same cycle, sp stays 4, ret_addr=0x04. A following LI gives we=0. Reset -> RUN, sp=0.
- RET at sp=0 -> halt=1, sp=0. With UC_STACK_WRAP_EN defined: halt=0, s_pila=1, sp=0.
- Reset asserted one cycle after a JAL push -> sp=0, ret_addr=0 next cycle.

Source files
------------

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - opcode encodings, FSM state and ALU op codes for the uc_stack control unit
package uc_pkg;

  localparam logic [5:0] OP_J   = 6'b110000;
  localparam logic [5:0] OP_JZ  = 6'b110001;
  localparam logic [5:0] OP_JNZ = 6'b110010;
  localparam logic [5:0] OP_JAL = 6'b110011;
  localparam logic [5:0] OP_RET = 6'b110100;

  localparam logic       ALU_PFX = 1'b0;
  localparam logic [1:0] LI_PFX  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } uc_state_e;

  typedef enum logic [2:0] {
    ALU_OP_0 = 3'b000,
    ALU_OP_1 = 3'b001,
    ALU_OP_2 = 3'b010,
    ALU_OP_3 = 3'b011,
    ALU_OP_4 = 3'b100,
    ALU_OP_5 = 3'b101,
    ALU_OP_6 = 3'b110,
    ALU_OP_7 = 3'b111
  } uc_alu_e;

  function automatic logic is_alu(input logic [5:0] op);
    return op[5] == ALU_PFX;
  endfunction

  function automatic logic is_li(input logic [5:0] op);
    return op[5:4] == LI_PFX;
  endfunction

endpackage

// File: rtl/uc_retstack.sv
// rtl/uc_retstack.sv - return-address LIFO; circular when UC_STACK_WRAP_EN is defined
module uc_retstack
  import uc_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [SP_W-1:0] sp,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]  stack_q [DEPTH];
  logic [PC_W-1:0]  stack_d [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [SP_W-1:0]  sp_q, sp_d;

  assign rd_ptr = wp_q - PTR_W'(1);
  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign sp     = sp_q;

`ifdef UC_STACK_WRAP_EN
  // Empty pop exposes the stale slot behind the write pointer.
  assign top = stack_q[rd_ptr];
`else
  assign top = empty ? '0 : stack_q[rd_ptr];
`endif

  // A push when full overwrites the oldest slot; sp saturates at DEPTH.
  always_comb begin
    stack_d = stack_q;
    wp_d    = wp_q;
    sp_d    = sp_q;
    if (push) begin
      stack_d[wp_q] = push_data;
      wp_d          = wp_q + PTR_W'(1);
      if (!full) sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      wp_d = rd_ptr;
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      wp_q <= '0;
      sp_q <= '0;
    end else begin
      stack_q <= stack_d;
      wp_q    <= wp_d;
      sp_q    <= sp_d;
    end
  end

endmodule

// File: rtl/uc_stack.sv
// rtl/uc_stack.sv - control unit with branches, call/return stack and fault FSM; option UC_STACK_WRAP_EN
module uc_stack
  import uc_pkg::*;
#(
  parameter  int OPC_W = 6,
  parameter  int PC_W  = 10,
  parameter  int DEPTH = 4,
  localparam int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic [PC_W-1:0]  pc_next,
  output logic             s_inc,
  output logic             s_pila,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       AluOP,
  output logic [PC_W-1:0]  ret_addr,
  output logic [SP_W-1:0]  sp,
  output logic             halt
);

`ifdef UC_STACK_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  uc_state_e state_q, state_d;
  uc_alu_e   alu_op;
  logic      push, pop, full, empty, halt_c;

  uc_retstack #(
    .PC_W (PC_W),
    .DEPTH(DEPTH),
    .SP_W (SP_W)
  ) u_retstack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_next),
    .sp       (sp),
    .top      (ret_addr),
    .full     (full),
    .empty    (empty)
  );

  // Defaults are the FAULT output values; reset leaves them with halt low.
  always_comb begin
    state_d = state_q;
    s_inc   = 1'b1;
    s_pila  = 1'b0;
    s_inm   = 1'b0;
    we      = 1'b0;
    wez     = 1'b0;
    alu_op  = ALU_OP_0;
    halt_c  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (reset) begin
      state_d = RUN;
    end else if (state_q == FAULT) begin
      halt_c = 1'b1;
    end else if (is_alu(opcode[5:0])) begin
      alu_op = uc_alu_e'(opcode[4:2]);
      we     = 1'b1;
      wez    = 1'b1;
    end else if (is_li(opcode[5:0])) begin
      s_inm = 1'b1;
      we    = 1'b1;
    end else begin
      case (opcode[5:0])
        OP_J:   s_inc = 1'b0;
        OP_JZ:  s_inc = ~zero;
        OP_JNZ: s_inc = zero;
        OP_JAL: begin
          if (full && !WRAP_EN) begin
            state_d = FAULT;
            halt_c  = 1'b1;
          end else begin
            s_inc = 1'b0;
            push  = 1'b1;
          end
        end
        OP_RET: begin
          if (empty && !WRAP_EN) begin
            state_d = FAULT;
            halt_c  = 1'b1;
          end else begin
            s_inc  = 1'b0;
            s_pila = 1'b1;
            pop    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign AluOP = alu_op;
  assign halt  = halt_c & ~WRAP_EN;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_uc_stack.sv
// tb/tb_uc_stack.sv - scoreboard bench for uc_stack (PC_W=8, DEPTH=4)
module tb_uc_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b100000;
  logic       zero = 1'b0;
  logic [7:0] pc_next = '0;
  logic       s_inc, s_pila, s_inm, we, wez, halt;
  logic [2:0] AluOP;
  logic [7:0] ret_addr;
  logic [2:0] sp;

  int total = 0;
  int bad = 0;
  int step_n = 0;

  typedef struct {
    int         id;
    logic       s_inc;
    logic       s_pila;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu;
    logic [7:0] ret;
    logic [2:0] sp;
    logic       halt;
  } exp_t;

  exp_t exp_q[$];

  uc_stack #(.OPC_W(6), .PC_W(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .zero    (zero),
    .pc_next (pc_next),
    .s_inc   (s_inc),
    .s_pila  (s_pila),
    .s_inm   (s_inm),
    .we      (we),
    .wez     (wez),
    .AluOP   (AluOP),
    .ret_addr(ret_addr),
    .sp      (sp),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic i_inc, input logic i_pila, input logic i_inm,
                              input logic i_we, input logic i_wez, input logic [2:0] i_alu,
                              input logic [7:0] i_ret, input logic [2:0] i_sp, input logic i_halt);
    exp_t e;
    e.id = 0; e.s_inc = i_inc; e.s_pila = i_pila; e.s_inm = i_inm; e.we = i_we; e.wez = i_wez;
    e.alu = i_alu; e.ret = i_ret; e.sp = i_sp; e.halt = i_halt;
    return e;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s got=%0h expected=%0h", id, name, got, want);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("s_inc",    e.id, 32'(s_inc),    32'(e.s_inc));
      chk("s_pila",   e.id, 32'(s_pila),   32'(e.s_pila));
      chk("s_inm",    e.id, 32'(s_inm),    32'(e.s_inm));
      chk("we",       e.id, 32'(we),       32'(e.we));
      chk("wez",      e.id, 32'(wez),      32'(e.wez));
      chk("AluOP",    e.id, 32'(AluOP),    32'(e.alu));
      chk("ret_addr", e.id, 32'(ret_addr), 32'(e.ret));
      chk("sp",       e.id, 32'(sp),       32'(e.sp));
      chk("halt",     e.id, 32'(halt),     32'(e.halt));
    end
  end

  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic [7:0] pcn, input exp_t e);
    @(posedge clk);
    #1;
    reset   = r;
    opcode  = op;
    zero    = z;
    pc_next = pcn;
    step_n++;
    e.id = step_n;
    exp_q.push_back(e);
  endtask

  localparam logic [5:0] LI  = 6'b100000;
  localparam logic [5:0] ALU = 6'b001000;
  localparam logic [5:0] JZ  = 6'b110001;
  localparam logic [5:0] JNZ = 6'b110010;
  localparam logic [5:0] JAL = 6'b110011;
  localparam logic [5:0] RET = 6'b110100;
  localparam logic [5:0] NOP = 6'b111111;

  initial begin
    int guard;
    //                       inc pila inm we wez alu    ret    sp   halt
    step(1, LI,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(1, LI,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, LI,  0, 8'h00, mk(1, 0, 1, 1, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, ALU, 0, 8'h00, mk(1, 0, 0, 1, 1, 3'b010, 8'h00, 3'd0, 0));
    step(0, JZ,  1, 8'h00, mk(0, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, JZ,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, JNZ, 1, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, JNZ, 0, 8'h00, mk(0, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    // three calls then three returns
    step(0, JAL, 0, 8'h11, mk(0, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, JAL, 0, 8'h22, mk(0, 0, 0, 0, 0, 3'b000, 8'h11, 3'd1, 0));
    step(0, JAL, 0, 8'h33, mk(0, 0, 0, 0, 0, 3'b000, 8'h22, 3'd2, 0));
    step(0, RET, 0, 8'h00, mk(0, 1, 0, 0, 0, 3'b000, 8'h33, 3'd3, 0));
    step(0, RET, 0, 8'h00, mk(0, 1, 0, 0, 0, 3'b000, 8'h22, 3'd2, 0));
    step(0, RET, 0, 8'h00, mk(0, 1, 0, 0, 0, 3'b000, 8'h11, 3'd1, 0));
    step(0, NOP, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    // fill the stack, then overflow
    step(0, JAL, 0, 8'h01, mk(0, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(0, JAL, 0, 8'h02, mk(0, 0, 0, 0, 0, 3'b000, 8'h01, 3'd1, 0));
    step(0, JAL, 0, 8'h03, mk(0, 0, 0, 0, 0, 3'b000, 8'h02, 3'd2, 0));
    step(0, JAL, 0, 8'h04, mk(0, 0, 0, 0, 0, 3'b000, 8'h03, 3'd3, 0));
`ifdef UC_STACK_WRAP_EN
    step(0, JAL, 0, 8'h05, mk(0, 0, 0, 0, 0, 3'b000, 8'h04, 3'd4, 0));
    step(0, LI,  0, 8'h00, mk(1, 0, 1, 1, 0, 3'b000, 8'h05, 3'd4, 0));
    step(1, LI,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h05, 3'd4, 0));
    step(0, RET, 0, 8'h00, mk(0, 1, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
`else
    step(0, JAL, 0, 8'h05, mk(1, 0, 0, 0, 0, 3'b000, 8'h04, 3'd4, 1));
    step(0, LI,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h04, 3'd4, 1));
    step(1, LI,  0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h04, 3'd4, 0));
    step(0, RET, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 1));
`endif
    step(1, NOP, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    // reset right after a push discards it
    step(0, JAL, 0, 8'h5A, mk(0, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));
    step(1, NOP, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h5A, 3'd1, 0));
    step(0, NOP, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'b000, 8'h00, 3'd0, 0));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
